// File: rtl/keccak_sponge_ctrl_if.sv
// Handshake and datapath bundle between the sponge controller, the block
// source, the permutation datapath and the digest consumer.
interface keccak_sponge_ctrl_if #(
  parameter int DIGEST_W = 512
);
  logic                blk_valid;
  logic [575:0]        blk_data;
  logic                blk_last;
  logic                blk_ready;
  logic [575:0]        perm_pin;
  logic                perm_firstround;
  logic                perm_first_blk;
  logic [1599:0]       perm_pout;
  logic [DIGEST_W-1:0] hash_out;
  logic                hash_valid;
  logic                hash_ack;
  logic                busy;

  // Environment side: block source, permutation result, digest consumer.
  modport master (
    output blk_valid, blk_data, blk_last, perm_pout, hash_ack,
    input  blk_ready, perm_pin, perm_firstround, perm_first_blk,
           hash_out, hash_valid, busy
  );

  // Controller side.
  modport slave (
    input  blk_valid, blk_data, blk_last, perm_pout, hash_ack,
    output blk_ready, perm_pin, perm_firstround, perm_first_blk,
           hash_out, hash_valid, busy
  );
endinterface

// File: rtl/keccak_sponge_ctrl.sv
// Keccak sponge absorb controller: accepts padded rate blocks, strobes the
// permutation datapath once per block, counts rounds and captures the digest.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for the first block of a new message
// LOAD    | one-cycle load strobe into the permutation datapath
// PERMUTE | ROUNDS cycles of permutation, round counter running
// WAITBLK | waiting for the next block of the current message
// DONE    | digest held until downstream acknowledges it
module keccak_sponge_ctrl #(
  parameter int ROUNDS   = 24,
  parameter int DIGEST_W = 512
) (
  input logic              clk,
  input logic              rst,
  keccak_sponge_ctrl_if.slave bus
);

  localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    PERMUTE = 3'd2,
    WAITBLK = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic [575:0]        blk_q, blk_d;
  logic                ready_q, ready_d;
  logic [DIGEST_W-1:0] hash_q, hash_d;
  logic                hvalid_q, hvalid_d;

  // Only the digest slice of the permutation state is consumed here.
  logic unused_pout;
  assign unused_pout = ^bus.perm_pout[1599:DIGEST_W];

  // State and datapath registers; reset aborts any message in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      blk_q    <= '0;
      ready_q  <= 1'b0;
      hash_q   <= '0;
      hvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      last_q   <= last_d;
      blk_q    <= blk_d;
      ready_q  <= ready_d;
      hash_q   <= hash_d;
      hvalid_q <= hvalid_d;
    end
  end

  // Next-state, round counter and capture logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    last_d   = last_q;
    blk_d    = blk_q;
    hash_d   = hash_q;
    hvalid_d = hvalid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.blk_valid && ready_q) begin
          blk_d   = bus.blk_data;
          last_d  = bus.blk_last;
          first_d = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = PERMUTE;
      end
      PERMUTE: begin
        // Counter parks at the terminal count instead of wrapping.
        if (cnt_q == CNT_LAST) begin
          if (last_q) begin
            hash_d   = bus.perm_pout[DIGEST_W-1:0];
            hvalid_d = 1'b1;
            state_d  = DONE;
          end else begin
            state_d  = WAITBLK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAITBLK: begin
        if (bus.blk_valid && ready_q) begin
          blk_d   = bus.blk_data;
          last_d  = bus.blk_last;
          first_d = 1'b0;
          state_d = LOAD;
        end
      end
      DONE: begin
        if (bus.hash_ack && hvalid_q) begin
          hvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is a registered decode of the upcoming state, so it stays low
  // until the first clock edge after reset and never follows blk_valid.
  assign ready_d = (state_d == IDLE) || (state_d == WAITBLK);

  assign bus.blk_ready       = ready_q;
  assign bus.perm_pin        = blk_q;
  assign bus.perm_firstround = (state_q == LOAD);
  assign bus.perm_first_blk  = (state_q == LOAD) && first_q;
  assign bus.hash_out        = hash_q;
  assign bus.hash_valid      = hvalid_q;
  assign bus.busy            = (state_q != IDLE);

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Directed-random bench for the sponge controller. The reference is a
// message-level model: each message is a list of random blocks, the first
// one loads into a fresh state, every block costs 1+ROUNDS cycles from
// accept, and the digest is the low slice of the permutation state present
// when the final block finishes.
module tb_keccak_sponge_ctrl;
  localparam int ROUNDS = 24;
  localparam int DW     = 512;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  keccak_sponge_ctrl_if #(.DIGEST_W(DW)) bus();

  keccak_sponge_ctrl #(.ROUNDS(ROUNDS), .DIGEST_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int digests = 0;
  int exp_pulses = 0;
  int exp_digests = 0;
  logic hv_prev = 1'b0;
  logic [1599:0] exp_state;

  // Independent event counters for strobes and digest deliveries.
  always @(posedge clk) begin
    if (bus.perm_firstround) pulses++;
    if (bus.hash_valid && !hv_prev) digests++;
    hv_prev = bus.hash_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [575:0] rnd576();
    logic [575:0] v;
    for (int i = 0; i < 18; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [1599:0] rnd1600();
    logic [1599:0] v;
    for (int i = 0; i < 50; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk_rst(input string tag);
    chk1({tag, "_blk_ready"},   bus.blk_ready, 1'b0);
    chk1({tag, "_firstround"},  bus.perm_firstround, 1'b0);
    chk1({tag, "_first_blk"},   bus.perm_first_blk, 1'b0);
    chkw({tag, "_perm_pin"},    bus.perm_pin, '0);
    chkw({tag, "_hash_out"},    {64'b0, bus.hash_out}, '0);
    chk1({tag, "_hash_valid"},  bus.hash_valid, 1'b0);
    chk1({tag, "_busy"},        bus.busy, 1'b0);
  endtask

  task automatic release_rst();
    rst = 1'b1;
    chk1("rel_ready_pre_edge", bus.blk_ready, 1'b0);
    tick();
    chk1("rel_ready_post_edge", bus.blk_ready, 1'b1);
    chk1("rel_busy", bus.busy, 1'b0);
  endtask

  // Send one message of nblk random blocks. hold_valid keeps blk_valid high
  // with junk data while the controller is not ready. abort_k > 0 pulls
  // reset k cycles after the first accept (round index k-1 in progress).
  task automatic send_msg(input int nblk, input bit hold_valid, input int abort_k);
    logic [575:0]  data;
    logic [1599:0] pout;
    int n;
    for (int b = 0; b < nblk; b++) begin
      data = rnd576();
      bus.blk_data  = data;
      bus.blk_last  = (b == nblk - 1);
      bus.blk_valid = 1'b1;
      n = 0;
      while (!bus.blk_ready && n < 60) begin
        tick();
        n++;
      end
      chk1("ready_within_bound", bus.blk_ready, 1'b1);
      tick();
      exp_pulses++;
      if (hold_valid) begin
        bus.blk_data = rnd576();
        bus.blk_last = 1'($urandom_range(0, 1));
      end else begin
        bus.blk_valid = 1'b0;
        bus.blk_data  = rnd576();
      end
      chk1("load_firstround", bus.perm_firstround, 1'b1);
      chk1("load_first_blk", bus.perm_first_blk, (b == 0));
      chkw("load_perm_pin", bus.perm_pin, data);
      chk1("load_ready", bus.blk_ready, 1'b0);
      chk1("load_busy", bus.busy, 1'b1);
      for (int k = 1; k <= ROUNDS + 1; k++) begin
        pout = rnd1600();
        bus.perm_pout = pout;
        bus.hash_ack  = (k <= ROUNDS) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (hold_valid) bus.blk_data = rnd576();
        tick();
        if (k == abort_k) begin
          rst = 1'b0;
          #1;
          chk_rst("abort");
          bus.blk_valid = 1'b0;
          bus.hash_ack  = 1'b0;
          return;
        end
        if (k <= ROUNDS) begin
          chk1("perm_firstround", bus.perm_firstround, 1'b0);
          chk1("perm_ready", bus.blk_ready, 1'b0);
          chkw("perm_pin_hold", bus.perm_pin, data);
          chk1("perm_hash_valid", bus.hash_valid, 1'b0);
        end else if (b == nblk - 1) begin
          exp_state = pout;
          exp_digests++;
          chk1("done_hash_valid", bus.hash_valid, 1'b1);
          chkw("done_hash_out", {64'b0, bus.hash_out}, {64'b0, pout[DW-1:0]});
          chk1("done_ready", bus.blk_ready, 1'b0);
        end else begin
          chk1("wait_ready", bus.blk_ready, 1'b1);
          chk1("wait_hash_valid", bus.hash_valid, 1'b0);
        end
      end
    end
    bus.blk_valid = 1'b0;
    bus.hash_ack  = 1'b0;
  endtask

  task automatic finish_msg(input int hold);
    for (int i = 0; i < hold; i++) begin
      bus.hash_ack = 1'b0;
      tick();
      chk1("hold_hash_valid", bus.hash_valid, 1'b1);
      chkw("hold_hash_out", {64'b0, bus.hash_out}, {64'b0, exp_state[DW-1:0]});
      chk1("hold_ready", bus.blk_ready, 1'b0);
      chk1("hold_busy", bus.busy, 1'b1);
    end
    bus.hash_ack = 1'b1;
    tick();
    bus.hash_ack = 1'b0;
    chk1("ack_hash_valid", bus.hash_valid, 1'b0);
    chkw("ack_hash_out_kept", {64'b0, bus.hash_out}, {64'b0, exp_state[DW-1:0]});
    chk1("ack_ready", bus.blk_ready, 1'b1);
    chk1("ack_busy", bus.busy, 1'b0);
  endtask

  initial begin
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.blk_last  = 1'b0;
    bus.perm_pout = '0;
    bus.hash_ack  = 1'b0;

    // Reset held across clock edges, then released.
    #2;
    chk_rst("reset");
    tick();
    tick();
    chk_rst("reset_clocked");
    release_rst();

    // Spurious acknowledge in IDLE.
    bus.hash_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("idle_ack_ready", bus.blk_ready, 1'b1);
      chk1("idle_ack_busy", bus.busy, 1'b0);
      chk1("idle_ack_hash_valid", bus.hash_valid, 1'b0);
    end
    bus.hash_ack = 1'b0;

    // Single-block message.
    send_msg(1, 1'b0, 0);
    finish_msg(0);

    // Three blocks with blk_valid held high throughout, digest held 10 cycles.
    send_msg(3, 1'b1, 0);
    finish_msg(10);

    // Random-length message with random acknowledge delay.
    send_msg(int'($urandom_range(2, 4)), 1'($urandom_range(0, 1)), 0);
    finish_msg(int'($urandom_range(0, 4)));

    // Reset during round 12 of the first block.
    send_msg(2, 1'b0, 13);
    release_rst();
    send_msg(1, 1'b0, 0);
    finish_msg(1);

    // Reset while the digest is waiting for acknowledge.
    send_msg(1, 1'b0, 0);
    tick();
    rst = 1'b0;
    #1;
    chk_rst("done_abort");
    release_rst();
    send_msg(2, 1'b0, 0);
    finish_msg(2);

    tick();
    chki("strobe_count", pulses, exp_pulses);
    chki("digest_count", digests, exp_digests);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keccak_sponge_ctrl.md
KECCAK_SPONGE_CTRL -- requirements
Module: keccak_sponge_ctrl

Interface
REQ-001 Parameter ROUNDS, default 24: permutation round count per absorbed block.
REQ-002 Parameter DIGEST_W, default 512: digest width in bits.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
REQ-005 blk_valid  in  1  upstream offers one 576-bit rate block.
REQ-006 blk_data  in  576  rate block, already padded by upstream.
REQ-007 blk_last  in  1  qualifies blk_data as the final block of the message.
REQ-008 blk_ready  out  1  controller accepts blk_data this cycle.
REQ-009 perm_pin  out  576  rate block presented to the permutation datapath.
REQ-010 perm_firstround  out  1  one-cycle load strobe: the datapath XORs perm_pin into its state and starts round 0.
REQ-011 perm_first_blk  out  1  qualifies perm_firstround: 1 means XOR into an all-zero state (new message), 0 means XOR into the retained state.
REQ-012 perm_pout  in  1600  permutation state output, valid in the cycle after the last round.
REQ-013 hash_out  out  DIGEST_W  digest, equal to perm_pout[DIGEST_W-1:0] captured at completion.
REQ-014 hash_valid  out  1  digest available.
REQ-015 hash_ack  in  1  downstream consumes the digest.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, PERMUTE, WAITBLK and DONE, and no others.
REQ-018 IDLE: blk_ready=1; on blk_valid&blk_ready, register blk_data/blk_last, set first_flag=1, go LOAD.
REQ-019 LOAD: lasts exactly one cycle; perm_firstround=1, perm_first_blk=first_flag, perm_pin=registered block; round_cnt cleared to 0; go PERMUTE.
REQ-020 PERMUTE: round_cnt increments once per cycle; perm_firstround=0; perm_pin holds its value.
REQ-021 When round_cnt==ROUNDS-1 the FSM SHALL go DONE if the stored last=1, else WAITBLK.
REQ-022 Per-block latency: accept edge to exit of PERMUTE SHALL be 1+ROUNDS cycles (LOAD + ROUNDS PERMUTE cycles).
REQ-023 WAITBLK: blk_ready=1; on handshake, register the block, clear first_flag, go LOAD (perm_first_blk=0).
REQ-024 blk_ready SHALL be 0 in LOAD, PERMUTE and DONE; blk_data SHALL be ignored whenever blk_ready=0.
REQ-025 The transition into DONE SHALL capture perm_pout[DIGEST_W-1:0] into hash_out and set hash_valid=1.
REQ-026 DONE: hash_out and hash_valid SHALL hold until hash_ack=1; on hash_ack, clear hash_valid and go IDLE (hash_out retains its value).
REQ-027 A hash_ack received while hash_valid=0 SHALL be ignored.
REQ-028 round_cnt SHALL be $clog2(ROUNDS) bits wide and SHALL never exceed ROUNDS-1 (no wrap past the terminal count).
REQ-029 blk_valid with blk_last=1 accepted in IDLE SHALL produce a single-block message (first_flag=1, then DONE).
REQ-030 No output SHALL combinationally depend on blk_valid or hash_ack.

Reset
REQ-031 rst=0 SHALL force, asynchronously: state=IDLE, round_cnt=0, first_flag=0, blk_ready=0, perm_firstround=0, perm_first_blk=0, perm_pin=0, hash_out=0, hash_valid=0, busy=0.
REQ-032 blk_ready SHALL rise in the first clock cycle after rst deasserts (registered IDLE decode).
REQ-033 Reset asserted mid-PERMUTE or in DONE SHALL abort the message with no digest; the next accepted block SHALL be treated as first (perm_first_blk=1).

Verification
REQ-034 Single block, blk_last=1, ROUNDS=24 -> perm_firstround for 1 cycle with perm_first_blk=1; hash_valid rises 25 cycles after the accept edge; hash_out=perm_pout[511:0].
REQ-035 Three-block message -> three perm_firstround pulses with perm_first_blk=1,0,0; blk_ready low for 25 cycles after each accept; one digest only.
REQ-036 blk_valid held high during PERMUTE -> no accept until WAITBLK; each block consumed exactly once.
REQ-037 hash_ack withheld for 10 cycles -> hash_valid and hash_out stable for the whole wait; blk_ready=0; IDLE one cycle after hash_ack.
REQ-038 rst pulled low at round_cnt=12 -> all outputs at reset values immediately; next message shows perm_first_blk=1.
REQ-039 Spurious hash_ack in IDLE/PERMUTE -> no state change.
